// File: rtl/duc_tx_scheduler.sv
// duc_tx_scheduler: burst sequencer for the upconverter.
// Feeds exactly i_length baseband samples into the upconverter at the DAC rate,
// substituting zeros when the source runs dry, then drains the interpolation
// filter with FLUSH_CYCLES zero inputs and gates the DAC side to zero when idle.
module duc_tx_scheduler #(
    parameter int WIDTH        = 16,
    parameter int LEN_WIDTH    = 16,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_dac_strobe,
    input  logic                 i_start,
    input  logic [LEN_WIDTH-1:0] i_length,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_underflow,
    input  logic [WIDTH-1:0]     i_inph_data,
    input  logic [WIDTH-1:0]     i_quad_data,
    input  logic                 i_valid,
    output logic                 o_ack,
    output logic [WIDTH-1:0]     o_duc_inph,
    output logic [WIDTH-1:0]     o_duc_quad,
    output logic                 o_duc_ready,
    input  logic                 i_duc_sample_req,
    input  logic [WIDTH-1:0]     i_duc_inph,
    input  logic [WIDTH-1:0]     i_duc_quad,
    output logic [WIDTH-1:0]     o_dac_inph,
    output logic [WIDTH-1:0]     o_dac_quad,
    output logic                 o_dac_valid
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FLUSH_W-1:0]   FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);
    localparam logic [FLUSH_W-1:0]   FLUSH_ONE  = FLUSH_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remain;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic                 streaming;
    logic                 busy;
    logic                 take;

    // A sample slot is consumed only when the DAC ticks and the upconverter asks for input.
    assign streaming   = (state == STREAM);
    assign busy        = (state != IDLE);
    assign take        = streaming & i_dac_strobe & i_duc_sample_req;

    assign o_busy      = busy;
    assign o_duc_ready = i_dac_strobe & busy;
    assign o_ack       = take & i_valid & ~i_abort;
    assign o_duc_inph  = (streaming & i_valid) ? i_inph_data : '0;
    assign o_duc_quad  = (streaming & i_valid) ? i_quad_data : '0;

    // Burst sequencer: slot counting in STREAM, strobe-counted drain in FLUSH.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            remain      <= '0;
            flush_cnt   <= '0;
            o_done      <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_underflow <= 1'b0;
                        if (i_length != '0) begin
                            remain <= i_length;
                            state  <= STREAM;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (i_abort) begin
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end else if (take) begin
                        remain <= remain - LEN_ONE;
                        if (!i_valid) begin
                            o_underflow <= 1'b1;
                        end
                        if (remain == LEN_ONE) begin
                            flush_cnt <= FLUSH_LOAD;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (i_dac_strobe) begin
                        flush_cnt <= flush_cnt - FLUSH_ONE;
                        if (flush_cnt == FLUSH_ONE) begin
                            state  <= IDLE;
                            o_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // DAC side is registered once and held at zero whenever no burst is in progress.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dac_valid <= 1'b0;
            o_dac_inph  <= '0;
            o_dac_quad  <= '0;
        end else begin
            o_dac_valid <= i_dac_strobe & busy;
            o_dac_inph  <= busy ? i_duc_inph : '0;
            o_dac_quad  <= busy ? i_duc_quad : '0;
        end
    end

endmodule
